div_32: RTL and testbench

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32.sv | 123 ++++++++++++
 tb/tb_div_32.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_32.sv
`default_nettype none
// ============================================================================
// Module   : div_32
// Brief    : 32-bit unsigned restoring divider. It retires one quotient bit
//            per clock and has a fixed latency. Divide-by-zero is flagged and
//            finishes early with all-ones quotient.
// Revision : 1.0 - initial release
// ============================================================================
module div_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ina,
  input  logic [31:0] inb,
  input  logic        start,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0]  C_LAST_STEP = 5'd31;
  localparam logic [31:0] C_ALL_ONES  = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [31:0] r_part;
  logic [31:0] r_quo_sh;

  logic [32:0] w_t;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_part_next;
  logic [31:0] w_quo_next;

  // One restoring step. The remainder stays below the divisor, so the shifted
  // trial value fits in 33 bits. The 33-bit subtraction borrows exactly
  // when t < divisor, so its top bit provides the compare result.
  always_comb begin
    w_t         = {r_part, r_dividend[31]};
    w_diff      = w_t - {1'b0, r_divisor};
    w_ge        = ~w_diff[32];
    w_part_next = w_ge ? w_diff[31:0] : w_t[31:0];
    w_quo_next  = {r_quo_sh[30:0], w_ge};
  end

  // Control FSM and datapath. Visible results move only on completion, so
  // quo/rem/div_zero hold through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= 5'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_part     <= 32'd0;
      r_quo_sh   <= 32'd0;
      quo        <= 32'd0;
      rem        <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            if (inb == 32'd0) begin
              // Zero divisor bypasses RUN and completes on the next cycle.
              r_state  <= S_DONE;
              quo      <= C_ALL_ONES;
              rem      <= ina;
              div_zero <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
            end else begin
              r_state    <= S_RUN;
              r_dividend <= ina;
              r_divisor  <= inb;
              r_part     <= 32'd0;
              r_quo_sh   <= 32'd0;
              r_count    <= 5'd0;
              busy       <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        S_RUN: begin
          r_part     <= w_part_next;
          r_quo_sh   <= w_quo_next;
          r_dividend <= {r_dividend[30:0], 1'b0};
          r_count    <= r_count + 5'd1;
          if (r_count == C_LAST_STEP) begin
            r_state  <= S_DONE;
            quo      <= w_quo_next;
            rem      <= w_part_next;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_32
// Brief    : Directed self-checking bench for div_32 using hand-computed
//            quotient/remainder vectors, latency and control-flag checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] ina;
  logic [31:0] inb;
  logic        start;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  div_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ina      (ina),
    .inb      (inb),
    .start    (start),
    .quo      (quo),
    .rem      (rem),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one division and check the result, the latency and the control
  // flags. Latency is counted in rising edges from the first edge that sees
  // start: elat = 33 for a normal division and 1 for divide-by-zero.
  // 'hold' leaves start high and returns on the negedge where done is seen.
  // 'inject' pulses start with other operands during RUN cycle 10.
  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input int ebusy, input bit hold, input bit inject);
    int n, busy_n, overlap, qchg;
    logic [31:0] q0, r0;
    n = 0; busy_n = 0; overlap = 0; qchg = 0;
    @(negedge clk);
    q0 = quo; r0 = rem;
    ina = a; inb = b; start = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (inject && n == 11) begin
        start = 1'b1; ina = 32'd999; inb = 32'd5;
      end
      if (busy && done) overlap++;
      if (busy) busy_n++;
      if (busy && (quo !== q0 || rem !== r0)) qchg++;
      if (done) break;
    end
    check({name, ".latency"},  n, elat);
    check({name, ".busy_cyc"}, busy_n, ebusy);
    check({name, ".overlap"},  overlap, 0);
    check({name, ".hold_run"}, qchg, 0);
    check({name, ".quo"},      quo, eq);
    check({name, ".rem"},      rem, er);
    check({name, ".div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      check({name, ".done_1cyc"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, busy_n, dones;
    rst_n = 1'b0; start = 1'b0; ina = 32'd0; inb = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.quo",  quo, 32'd0);
    check("rst.rem",  rem, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.dz",   {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;

    do_div("d100_7",  32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, 1'b0, 1'b0);
    do_div("dmax_1",  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 32, 1'b0, 1'b0);
    do_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33, 32, 1'b0, 1'b0);
    do_div("d5_0",    32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, 1'b0, 1'b0);
    do_div("d3_10",   32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, 32, 1'b0, 1'b1);

    // Asynchronous reset during RUN cycle 16, applied between clock edges.
    @(negedge clk);
    ina = 32'd100; inb = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    check("abort.busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.quo",  quo, 32'd0);
    check("abort.rem",  rem, 32'd0);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.dz",   {31'd0, div_zero}, 32'd0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort.start_in_rst", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort.no_done", dones, 0);
    do_div("d1000_33", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33, 32, 1'b0, 1'b0);

    // Start held high: the second operands are resampled at the first DONE.
    do_div("b2b_1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, 1'b1, 1'b0);
    ina = 32'd81; inb = 32'd9;
    n = 0; busy_n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) break;
    end
    start = 1'b0;
    check("b2b_2.spacing",  n, 33);
    check("b2b_2.busy_cyc", busy_n, 32);
    check("b2b_2.quo",      quo, 32'd9);
    check("b2b_2.rem",      rem, 32'd0);
    check("b2b_2.div_zero", {31'd0, div_zero}, 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
